// File: rtl/rambam_serial_multiplier.sv
// Digit-serial RAMBAM multiplier over GF(2)[x]/PQ(x), consuming DIGIT coefficients of a per cycle.
// Optional refresh term r(x)*P(x) is enabled by defining RAMBAM_REFRESH_EN.
module rambam_serial_multiplier #(
  parameter int           d     = 0,
  parameter logic [8+d:0] PQ    = 9'h11B,
  parameter logic [8:0]   P     = 9'h11B,
  parameter int           DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7+d:0]   a,
  input  logic [7+d:0]   b,
`ifdef RAMBAM_REFRESH_EN
  input  logic [d-1:0]   r,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7+d:0]   out
);

  localparam int W  = 8 + d;
  localparam int N  = W / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || (W % DIGIT) != 0) begin : g_bad_digit
    $error("DIGIT must divide 8+d");
  end
  if (PQ[W] != 1'b1 || P[8] != 1'b1) begin : g_bad_poly
    $error("PQ and P must be monic of degree 8+d and 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, b_reg, acc_reg, out_reg;
  logic [W-1:0]   b_next, acc_next, refresh_term;
  logic [CW-1:0]  cnt_reg;
  logic           load_ops, step, last_cycle;

  assign last_cycle = (cnt_reg == CW'(N - 1));
  assign out        = out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_ops   = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_ops   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last_cycle) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // DIGIT shift-and-add stages; a_reg is pre-shifted so the current digit sits in its low bits
  always_comb begin
    b_next   = b_reg;
    acc_next = acc_reg;
    for (int j = 0; j < DIGIT; j++) begin
      if (a_reg[j]) begin
        acc_next = acc_next ^ b_next;
      end
      b_next = {b_next[W-2:0], 1'b0} ^ (b_next[W-1] ? PQ[W-1:0] : '0);
    end
  end

`ifdef RAMBAM_REFRESH_EN
  logic [d-1:0]        r_reg;
  logic [d-1:0][W-1:0] rp_terms;

  genvar gi;
  for (gi = 0; gi < d; gi++) begin : g_refresh
    assign rp_terms[gi] = r_reg[gi] ? (W'(P) << gi) : '0;
  end

  // deg(r*P) < 8+d, so the refresh term never needs reduction
  always_comb begin
    refresh_term = '0;
    for (int j = 0; j < d; j++) begin
      refresh_term = refresh_term ^ rp_terms[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg <= '0;
    end else if (load_ops) begin
      r_reg <= r;
    end
  end
`else
  assign refresh_term = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
      cnt_reg <= '0;
      out_reg <= '0;
    end else if (load_ops) begin
      a_reg   <= a;
      b_reg   <= b;
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (step) begin
      a_reg   <= a_reg >> DIGIT;
      b_reg   <= b_next;
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + CW'(1);
      if (last_cycle) begin
        out_reg <= acc_next ^ refresh_term;
      end
    end
  end

endmodule

// File: tb/tb_rambam_serial_multiplier.sv
// Randomised bench for rambam_serial_multiplier (d=2, DIGIT=2) against a polynomial-arithmetic model.
module tb_rambam_serial_multiplier;

  localparam int           D     = 2;
  localparam int           W     = 8 + D;
  localparam int           DIGIT = 2;
  localparam int           N     = W / DIGIT;
  localparam logic [8:0]   P     = 9'h11B;
  localparam logic [W:0]   PQ    = 11'h741;   // (x^8+x^4+x^3+x+1)(x^2+x+1)

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, out;
  logic [D-1:0] r;

  rambam_serial_multiplier #(.d(D), .PQ(PQ), .P(P), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef RAMBAM_REFRESH_EN
    .r(r),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int accepted = 0;
  int delivered = 0;

  typedef struct {
    logic [W-1:0] val;
    int           ready_cyc;
  } item_t;
  item_t        q[$];
  logic [W-1:0] last_out = '0;

  function automatic logic [31:0] clmul(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] res = '0;
    for (int i = 0; i < 16; i++) if (y[i]) res = res ^ (x << i);
    return res;
  endfunction

  function automatic logic [31:0] pmod(input logic [31:0] x, input logic [31:0] m);
    int dm = 0;
    for (int i = 0; i < 32; i++) if (m[i]) dm = i;
    for (int i = 31; i >= dm; i--) if (x[i]) x = x ^ (m << (i - dm));
    return x;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic [D-1:0] rv);
    logic [31:0] res = pmod(clmul(32'(av), 32'(bv)), 32'(PQ));
`ifdef RAMBAM_REFRESH_EN
    res = res ^ clmul(32'(rv), 32'(P));
`else
    res = res ^ (32'(rv) & 32'h0);
`endif
    return res[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Per-cycle compare: in_ready, out_valid and out derived from the queue of in-flight operations
  initial forever begin
    bit           rdy_m, exp_valid;
    logic [W-1:0] exp_out;
    @(negedge clk);
    if (!rst_n) begin
      accepted = accepted - q.size();
      q.delete();
      last_out = '0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out", 32'(out), 32'd0);
    end else begin
      rdy_m     = (q.size() == 0);
      exp_valid = (q.size() != 0) && (cyc >= q[0].ready_cyc);
      exp_out   = exp_valid ? q[0].val : last_out;
      chk("in_ready", 32'(in_ready), 32'(rdy_m));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out", 32'(out), 32'(exp_out));
      if (exp_valid && out_ready) begin
        last_out = q[0].val;
        void'(q.pop_front());
        delivered++;
      end
      if (in_valid && rdy_m) begin
        q.push_back('{val: model(a, b, r), ready_cyc: cyc + 1 + N});
        accepted++;
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [D-1:0] rv, input bit keep);
    int n = 0;
    bit got = 0;
    a = av; b = bv; r = rv; in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    if (!keep) in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); r = D'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
    end
  endtask

  initial begin
    logic [W-1:0] av, bv;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; r = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    chk("model_57x83", pmod(clmul(32'h57, 32'h83), 32'(P)), 32'hC1);
    chk("model_57x13", pmod(clmul(32'h57, 32'h13), 32'(P)), 32'hFE);
    chk("model_a_one", 32'(model(10'h001, 10'h2A5, 2'b00)), 32'h2A5);

    send(10'h057, 10'h083, 2'b00, 0);
    wait_idle(50);
    chk("dut_57x83_modP", pmod(32'(out), 32'(P)), 32'hC1);
    bv = W'($urandom);
    send(10'h001, bv, 2'b00, 0);
    wait_idle(50);
    chk("dut_a_one", 32'(out), 32'(bv));
`ifdef RAMBAM_REFRESH_EN
    bv = W'($urandom);
    send(10'h001, bv, 2'b01, 0);
    wait_idle(50);
    chk("refresh_r1", 32'(out), 32'(bv ^ W'(P)));
    av = W'($urandom); bv = W'($urandom);
    send(av, bv, D'($urandom), 0);
    wait_idle(50);
    chk("refresh_modP", pmod(32'(out), 32'(P)), pmod(clmul(32'(av), 32'(bv)), 32'(P)));
`endif

    // backpressure: stall DONE for 5 cycles while in_valid pulses
    ready_mode = 2;
    send(W'($urandom), W'($urandom), D'($urandom), 0);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
    chk("bp_reached_done", 32'(out_valid), 32'd1);
    repeat (5) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    ready_mode = 0;
    wait_idle(50);

    // asynchronous reset during the third BUSY cycle
    send(W'($urandom), W'($urandom), D'($urandom), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out", 32'(out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(10'h057, 10'h013, 2'b00, 0);
    wait_idle(50);
    chk("post_rst_57x13_modP", pmod(32'(out), 32'(P)), 32'hFE);

    // back-to-back with in_valid held high
    for (int i = 0; i < 20; i++) send(W'($urandom), W'($urandom), D'($urandom), 1);
    in_valid = 1'b0;
    wait_idle(100);

    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom), W'($urandom), D'($urandom), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle(200);
    ready_mode = 0;
    chk("delivered_count", 32'(delivered), 32'(accepted));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
